// File: rtl/switch_box_connector_pipe.sv
// Bidirectional switch-box connector between a W0-wide and a W1-wide routing bus.
// The rotation offsets and output masks are loaded through a serial shadow chain and committed by cfg_load.
module switch_box_connector_pipe #(
  parameter int W0   = 3,
  parameter int W1   = 10,
  parameter int PIPE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W0-1:0] data0_in,
  input  logic [W1-1:0] data1_in,
  output logic [W0-1:0] data0_out,
  output logic [W1-1:0] data1_out,
  input  logic          cfg_en,
  input  logic          cfg_in,
  input  logic          cfg_load,
  output logic          cfg_out
);

  localparam int C0 = (W1 > 1) ? $clog2(W1) : 1;
  localparam int C1 = (W0 > 1) ? $clog2(W0) : 1;
  localparam int L  = C0 + C1 + W0 + W1;

  // The field order matches the chain: off0 sits at the MSB end and mask1 at the LSB end.
  typedef struct packed {
    logic [C0-1:0] off0;
    logic [C1-1:0] off1;
    logic [W0-1:0] mask0;
    logic [W1-1:0] mask1;
  } cfg_t;

  localparam cfg_t CFG_RST = '{off0: '0, off1: '0, mask0: '1, mask1: '1};

  cfg_t shadow_q, shadow_d;
  cfg_t active_q, active_d;

  // NOTE: give every always_comb output a default first. A path that leaves an output unassigned infers a latch.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    // The load takes the pre-shift shadow, so a shift in the same cycle does not affect it.
    if (cfg_load) begin
      active_d      = shadow_q;
      active_d.off0 = C0'(32'(shadow_q.off0) % W1);
      active_d.off1 = C1'(32'(shadow_q.off1) % W0);
    end
    if (cfg_en) begin
      shadow_d = cfg_t'({shadow_q[L-2:0], cfg_in});
    end
  end

  // NOTE: use non-blocking assignments for state. Then every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= CFG_RST;
      active_q <= CFG_RST;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign cfg_out = shadow_q[L-1];

  logic [W0-1:0] m0;
  logic [W1-1:0] m1;

  // Rotated selection. The offsets are already reduced, so the source index is a compare over the source lanes.
  always_comb begin
    m0 = '0;
    m1 = '0;
    for (int k = 0; k < W0; k++) begin
      for (int j = 0; j < W1; j++) begin
        if (((k + int'(active_q.off0)) % W1) == j) begin
          m0[k] = active_q.mask0[k] & data1_in[j];
        end
      end
    end
    for (int k = 0; k < W1; k++) begin
      for (int j = 0; j < W0; j++) begin
        if (((k + int'(active_q.off1)) % W0) == j) begin
          m1[k] = active_q.mask1[k] & data0_in[j];
        end
      end
    end
  end

  if (PIPE == 0) begin : g_comb
    assign data0_out = m0;
    assign data1_out = m1;
  end else begin : g_pipe
    logic [W0-1:0] pipe0_q [PIPE];
    logic [W0-1:0] pipe0_d [PIPE];
    logic [W1-1:0] pipe1_q [PIPE];
    logic [W1-1:0] pipe1_d [PIPE];

    always_comb begin
      pipe0_d[0] = m0;
      pipe1_d[0] = m1;
      for (int i = 1; i < PIPE; i++) begin
        pipe0_d[i] = pipe0_q[i-1];
        pipe1_d[i] = pipe1_q[i-1];
      end
    end

    // NOTE: the pipeline stages are reset even though they only carry data. The outputs must read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE; i++) begin
          pipe0_q[i] <= '0;
          pipe1_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < PIPE; i++) begin
          pipe0_q[i] <= pipe0_d[i];
          pipe1_q[i] <= pipe1_d[i];
        end
      end
    end

    assign data0_out = pipe0_q[PIPE-1];
    assign data1_out = pipe1_q[PIPE-1];
  end

endmodule
